// File: rtl/dma_dev_pkg.sv
// Shared definitions for the DMA device port: FSM state encoding and default sizing.
// No logic, so no latency.
// No flow control of its own.
package dma_dev_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_THRESH = 1;

endpackage

// File: rtl/dma_fifo.sv
// Byte FIFO with a synchronous reset and a combinational head output; it reports occupancy.
// Push and pop take effect on the clock edge. The head updates in the same cycle as a pop.
// A push while full is dropped (push_drop) unless a pop frees a slot in that cycle. A pop while empty is ignored.
module dma_fifo
#(
    parameter int DEPTH = 16
)
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       pop_vld,
    output logic [7:0] pop_dat,
    output logic       full,
    output logic       empty,
    output logic [6:0] level,
    output logic       push_drop
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [6:0] DEPTH_L = 7'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [6:0]    cnt;
    logic          pop_ok;
    logic          push_ok;

    assign empty     = (cnt == 7'd0);
    assign full      = (cnt == DEPTH_L);
    assign pop_ok    = pop_vld & ~empty;
    // A full FIFO still accepts a push when a pop drains a slot in the same cycle.
    assign push_ok   = push_vld & (~full | pop_ok);
    assign push_drop = push_vld & ~push_ok;
    assign pop_dat   = mem[rd_ptr];
    assign level     = cnt;

    // Pointers wrap naturally at DEPTH (power of two). When a push and a pop occur together, the count does not change.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= 7'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      cnt <= cnt + 7'd1;
            else if (pop_ok && !push_ok) cnt <= cnt - 7'd1;
        end
    end

    // Storage write. Suppressed during reset so that the reset cycle moves no data.
    always_ff @(posedge iClk) begin
        if (!iRst && push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/dma_dev_port.sv
// Device-side DMA port: it joins a byte FIFO to a DREQ/DACK controller channel (optional TC: DMA_DEV_TC_EN).
// After DACK is sampled high, one byte moves on the next edge. DREQ can re-assert 2 cycles after DACK is sampled low.
// The FIFO level gates DREQ (THRESH bytes or free slots). Dropped pushes set the sticky oOvf flag.
module dma_dev_port
    import dma_dev_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int THRESH = DEF_THRESH
)
(
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iArm,
    input  logic       iDir,
    input  logic       iPush,
    input  logic [7:0] iPushData,
    input  logic       iPop,
    output logic [7:0] oPopData,
    output logic       oFull,
    output logic       oEmpty,
    output logic [6:0] oLevel,
    output logic       oOvf,
    output logic       oDREQ,
    input  logic       iDACK,
    input  logic       iTC,
    output logic [7:0] oDmaData,
    input  logic [7:0] iDmaData,
    output logic       oDone
);

    localparam logic [6:0] DEPTH_L  = 7'(DEPTH);
    localparam logic [6:0] THRESH_L = 7'(THRESH);

    state_t     state_q;
    state_t     state_d;
    logic       dir_q;
    logic       dir_d;
    logic       xfer;
    logic       dreq;
    logic       start_ok;
    logic       hold_idle;
    logic       ovf_q;
    logic [7:0] dma_q;
    logic       push_vld;
    logic [7:0] push_dat;
    logic       pop_vld;
    logic       push_drop;
    logic       dma_push;
    logic       dma_pop;
    logic [6:0] free_slots;

    // The DMA side owns one end of the FIFO only during XFER. The device strobes always apply.
    // A DMA write takes the single write port. A device push in that same cycle is not taken.
    assign dma_push = xfer & dir_q;
    assign dma_pop  = xfer & ~dir_q;
    assign push_vld = iPush | dma_push;
    assign push_dat = dma_push ? iDmaData : iPushData;
    assign pop_vld  = iPop | dma_pop;

    dma_fifo #(.DEPTH(DEPTH)) u_fifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .push_vld  (push_vld),
        .push_dat  (push_dat),
        .pop_vld   (pop_vld),
        .pop_dat   (oPopData),
        .full      (oFull),
        .empty     (oEmpty),
        .level     (oLevel),
        .push_drop (push_drop)
    );

    // The start test uses the live iDir. That value is then latched into dir_q for the transfer that follows.
    assign free_slots = DEPTH_L - oLevel;
    assign start_ok   = iDir ? (free_slots >= THRESH_L) : (oLevel >= THRESH_L);

    // Next-state and Moore outputs of the handshake FSM.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dreq    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (iArm && !hold_idle && start_ok) begin
                    state_d = REQ;
                    dir_d   = iDir;
                end
            end
            REQ: begin
                dreq = 1'b1;
                if (iDACK)      state_d = XFER;
                else if (!iArm) state_d = IDLE;
            end
            XFER: begin
                xfer    = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (!iDACK) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, the latched direction, sticky overflow, and the byte presented to the controller.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dma_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            if (push_drop) ovf_q <= 1'b1;
            if (dma_pop)   dma_q <= oPopData;
        end
    end

    assign oDREQ    = dreq;
    assign oOvf     = ovf_q;
    assign oDmaData = dma_q;

`ifdef DMA_DEV_TC_EN
    logic done_q;
    logic done_lat;
    logic arm_q;
    logic tc_hit;

    assign tc_hit    = xfer & iTC & iDACK;
    assign hold_idle = done_lat;
    assign oDone     = done_q;

    // A terminal count pulses oDone and parks the FSM in IDLE until iArm is re-armed with a rising edge.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            done_q   <= 1'b0;
            done_lat <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            arm_q  <= iArm;
            done_q <= tc_hit;
            if (tc_hit)               done_lat <= 1'b1;
            else if (iArm && !arm_q)  done_lat <= 1'b0;
        end
    end
`else
    logic unused_tc;

    assign unused_tc = iTC;
    assign hold_idle = 1'b0;
    assign oDone     = 1'b0;
`endif

endmodule
